// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
// Build option IO_ARB_LOCK_EN enables the atomic lock feature in the other files.
package io_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 14;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned LOCK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  // Peripheral register map; the arbiter itself never decodes these.
  localparam logic [ADDR_W_DEF-1:0] GPI0      = 14'd0;
  localparam logic [ADDR_W_DEF-1:0] GPI1      = 14'd1;
  localparam logic [ADDR_W_DEF-1:0] GPO0      = 14'd2;
  localparam logic [ADDR_W_DEF-1:0] GPO1      = 14'd3;
  localparam logic [ADDR_W_DEF-1:0] SPI       = 14'd4;
  localparam logic [ADDR_W_DEF-1:0] CONFSPI   = 14'd5;
  localparam logic [ADDR_W_DEF-1:0] UART      = 14'd6;
  localparam logic [ADDR_W_DEF-1:0] BAUD_LOW  = 14'd7;
  localparam logic [ADDR_W_DEF-1:0] BAUD_HIGH = 14'd8;
  localparam logic [ADDR_W_DEF-1:0] STATUS    = 14'd9;

endpackage

// File: rtl/io_arb_if.sv
// Per-master request/acknowledge port of the peripheral bus arbiter.
// The lock signal exists only when IO_ARB_LOCK_EN is defined.
interface io_arb_if
  import io_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
`ifdef IO_ARB_LOCK_EN
  logic              lock;
`endif
  logic              ack;
  logic [DATA_W-1:0] rdata;

`ifdef IO_ARB_LOCK_EN
  modport master (output req, addr, we, wdata, lock, input  ack, rdata);
  modport slave  (input  req, addr, we, wdata, lock, output ack, rdata);
`else
  modport master (output req, addr, we, wdata, input  ack, rdata);
  modport slave  (input  req, addr, we, wdata, output ack, rdata);
`endif
endinterface

// File: rtl/io_arb_rr2.sv
// Combinational two-way round-robin pick with an optional forced owner.
// When force_en is high only req[force_idx] can win (used to hold a lock).
module io_arb_rr2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       force_en,
  input  logic       force_idx,
  output logic       grant_idx,
  output logic       grant_valid
);

  logic [1:0] eff_req;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    eff_req     = req;
    grant_idx   = 1'b0;
    grant_valid = 1'b0;
    if (force_en) begin
      eff_req = req & (force_idx ? 2'b10 : 2'b01);
    end
    case (eff_req)
      2'b01: begin grant_idx = 1'b0;     grant_valid = 1'b1; end
      2'b10: begin grant_idx = 1'b1;     grant_valid = 1'b1; end
      2'b11: begin grant_idx = ~rr_last; grant_valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the single-ported peripheral register bus between two masters,
// round-robin, one registered access per 3 cycles. Option: IO_ARB_LOCK_EN.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  io_arb_if.slave           m0,
  io_arb_if.slave           m1,
  output logic              io_cs,
  output logic [ADDR_W-1:0] io_addr,
  output logic              io_write,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              busy
);

  if (LOCK_MAX == 0) begin : g_bad_lock_max
    $error("io_bus_arbiter: LOCK_MAX must be at least 1");
  end

  arb_state_t state;
  logic       owner;
  logic       rr_last;
  logic       grant_idx;
  logic       grant_valid;
  logic       force_en;
  logic       force_idx;

`ifdef IO_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  logic             lock_active;
  logic [CNT_W-1:0] lock_cnt;
  logic             grant_lock;

  // While a lock is held only the owner's request is eligible.
  assign force_en   = lock_active;
  assign force_idx  = owner;
  assign grant_lock = grant_idx ? m1.lock : m0.lock;
`else
  assign force_en   = 1'b0;
  assign force_idx  = 1'b0;
`endif

  io_arb_rr2 u_rr2 (
    .req         ({m1.req, m0.req}),
    .rr_last     (rr_last),
    .force_en    (force_en),
    .force_idx   (force_idx),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The io_* registers double as the request latch, so they are zero outside ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      io_cs    <= 1'b0;
      io_addr  <= '0;
      io_write <= 1'b0;
      io_wdata <= '0;
      busy     <= 1'b0;
      m0.ack   <= 1'b0;
      m1.ack   <= 1'b0;
      m0.rdata <= '0;
      m1.rdata <= '0;
`ifdef IO_ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_cnt    <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner    <= grant_idx;
            io_cs    <= 1'b1;
            io_addr  <= grant_idx ? m1.addr  : m0.addr;
            io_write <= grant_idx ? m1.we    : m0.we;
            io_wdata <= grant_idx ? m1.wdata : m0.wdata;
            busy     <= 1'b1;
            state    <= ISSUE;
`ifdef IO_ARB_LOCK_EN
            if (!lock_active) rr_last <= grant_idx;
            if (grant_lock) begin
              if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                lock_active <= 1'b0;
                lock_cnt    <= '0;
              end else begin
                lock_active <= 1'b1;
                lock_cnt    <= lock_cnt + 1'b1;
              end
            end else begin
              lock_active <= 1'b0;
              lock_cnt    <= '0;
            end
`else
            rr_last  <= grant_idx;
`endif
          end
        end

        ISSUE: begin
          if (!io_write) begin
            if (owner) m1.rdata <= io_rdata;
            else       m0.rdata <= io_rdata;
          end
          io_cs    <= 1'b0;
          io_addr  <= '0;
          io_write <= 1'b0;
          io_wdata <= '0;
          m0.ack   <= ~owner;
          m1.ack   <= owner;
          state    <= ACK;
        end

        ACK: begin
          m0.ack <= 1'b0;
          m1.ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          io_cs  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: vector table plus multi-cycle sequences
// for round-robin, reset abort and (with IO_ARB_LOCK_EN) the lock limit.
module tb_io_bus_arbiter;
  import io_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        io_cs;
  logic [13:0] io_addr;
  logic        io_write;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  io_arb_if m0_bus ();
  io_arb_if m1_bus ();

  io_bus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .io_cs    (io_cs),
    .io_addr  (io_addr),
    .io_write (io_write),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic        m0_req;
    logic        m0_we;
    logic [13:0] m0_addr;
    logic [15:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [13:0] m1_addr;
    logic [15:0] m1_wdata;
    logic [15:0] io_rdata;
    logic        e_cs;
    logic        e_write;
    logic [13:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_ack;    // {m1_ack, m0_ack}
    logic [15:0] e_rd0;
    logic [15:0] e_rd1;
    logic        e_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outputs_now();
    return 128'({io_cs, io_write, io_addr, io_wdata, m1_bus.ack, m0_bus.ack,
                 m0_bus.rdata, m1_bus.rdata, busy});
  endfunction

  task automatic drive(input vec_t v);
    m0_bus.req   = v.m0_req;
    m0_bus.we    = v.m0_we;
    m0_bus.addr  = v.m0_addr;
    m0_bus.wdata = v.m0_wdata;
    m1_bus.req   = v.m1_req;
    m1_bus.we    = v.m1_we;
    m1_bus.addr  = v.m1_addr;
    m1_bus.wdata = v.m1_wdata;
    io_rdata     = v.io_rdata;
  endtask

  // Waits (bounded) for the next ISSUE cycle; the owner is identified by address.
  task automatic wait_grant(output int who, output int cycles);
    who    = -1;
    cycles = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (io_cs && cycles == 0) begin
        who    = (io_addr == BAUD_LOW) ? 1 : 0;
        cycles = i;
        break;
      end
    end
  endtask

  int who;
  int cyc;
  int exp_seq [5];

  initial begin
    rst          = 1'b1;
    io_rdata     = '0;
    m0_bus.req   = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.req   = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0;
`ifdef IO_ARB_LOCK_EN
    m0_bus.lock  = 1'b0;
    m1_bus.lock  = 1'b0;
`endif

    //           m0 req we addr     wdata     m1 req we addr    wdata     io_rdata  cs we addr    wdata     ack    rd0       rd1       busy
    vecs[0]  = '{1'b1, 1'b1, GPO0, 16'h00A5, 1'b0, 1'b0, 14'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, GPO0,   16'h00A5, 2'b00, 16'h0000, 16'h0000, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, GPO0, 16'h00A5, 1'b0, 1'b0, 14'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 14'd0,  16'h0000, 2'b01, 16'h0000, 16'h0000, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b0, STATUS, 16'h0000, 16'h0002, 1'b0, 1'b0, 14'd0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b0, STATUS, 16'h0000, 16'h0002, 1'b1, 1'b0, STATUS, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b0, STATUS, 16'h0000, 16'h0002, 1'b0, 1'b0, 14'd0, 16'h0000, 2'b10, 16'h0000, 16'h0002, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, GPI1, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 14'd0,  16'h0000, 2'b00, 16'h0000, 16'h0002, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, GPI1, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 16'h5A5A, 1'b1, 1'b0, GPI1,   16'h0000, 2'b00, 16'h0000, 16'h0002, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, GPI1, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 14'd0,  16'h0000, 2'b01, 16'h5A5A, 16'h0002, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b1, SPI,   16'h0155, 16'hFFFF, 1'b0, 1'b0, 14'd0,  16'h0000, 2'b00, 16'h5A5A, 16'h0002, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b1, SPI,   16'h0155, 16'hFFFF, 1'b1, 1'b1, SPI,    16'h0155, 2'b00, 16'h5A5A, 16'h0002, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b1, SPI,   16'h0155, 16'hFFFF, 1'b0, 1'b0, 14'd0,  16'h0000, 2'b10, 16'h5A5A, 16'h0002, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 14'd0,  16'h0000, 2'b00, 16'h5A5A, 16'h0002, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", outputs_now(), 128'd0);
    rst = 1'b0;

    // Table: single-master write, read, read, write-does-not-touch-rdata
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), outputs_now(),
            128'({vecs[i].e_cs, vecs[i].e_write, vecs[i].e_addr, vecs[i].e_wdata,
                  vecs[i].e_ack, vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_busy}));
    end

    // Both masters hold req from reset: strict alternation starting with m0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_bus.req = 1'b1; m0_bus.we = 1'b1; m0_bus.addr = GPO1;     m0_bus.wdata = 16'h0A0A;
    m1_bus.req = 1'b1; m1_bus.we = 1'b1; m1_bus.addr = BAUD_LOW; m1_bus.wdata = 16'h0B0B;
    for (int k = 0; k < 8; k++) begin
      wait_grant(who, cyc);
      check($sformatf("rr_owner%0d", k), 128'(who), 128'(k % 2));
      check($sformatf("rr_gap%0d", k), 128'(cyc), (k == 0) ? 128'd1 : 128'd2);
      @(negedge clk);
      check($sformatf("rr_ack%0d", k), 128'({m1_bus.ack, m0_bus.ack}),
            (k % 2 == 1) ? 128'b10 : 128'b01);
    end
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset during ISSUE: cs drops at once, no ack, next tie goes to m0
    m0_bus.req = 1'b1;
    wait_grant(who, cyc);
    check("abort_pre_owner", 128'(who), 128'd0);
    m1_bus.req = 1'b1;
    #2 rst = 1'b1;
    #1 check("abort_cs_async", 128'({io_cs, busy}), 128'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_ack%0d", k), 128'({m1_bus.ack, m0_bus.ack, io_cs}), 128'd0);
    end
    rst = 1'b0;
    wait_grant(who, cyc);
    check("abort_post_owner", 128'(who), 128'd0);
    check("abort_post_gap", 128'(cyc), 128'd1);
    @(negedge clk);
    check("abort_post_ack", 128'({m1_bus.ack, m0_bus.ack}), 128'b01);
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // m1 requests with lock, m0 joins after m1's first grant
`ifdef IO_ARB_LOCK_EN
    m1_bus.lock = 1'b1;
    exp_seq = '{1, 1, 1, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0};
`endif
    m1_bus.req = 1'b1;
    wait_grant(who, cyc);
    check("lock_first_owner", 128'(who), 128'd1);
    m0_bus.req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      wait_grant(who, cyc);
      check($sformatf("lock_owner%0d", k + 2), 128'(who), 128'(exp_seq[k]));
      @(negedge clk);
    end
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;
`ifdef IO_ARB_LOCK_EN
    m1_bus.lock = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("final_idle", 128'({io_cs, busy, m1_bus.ack, m0_bus.ack}), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
